multi_clock_divider: RTL and testbench

Multi-channel programmable clock/tick generator that replaces single fixed-divisor dividers in the Pac-Man design. It derives CHANNELS independent divided outputs from one system clock, such as the game-logic tick, sprite-animation rate and ghost-mode timers. Each channel has:
- a runtime-programmable period and high time;
- a per-channel enable;
- glitch-free divisor updates, applied only at the period boundary;
- a global phase-sync input.

---
 rtl/multi_clock_divider_if.sv | 28 ++
 rtl/multi_clock_divider.sv | 107 ++++++++++
 tb/tb_multi_clock_divider.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multi_clock_divider_if.sv
// Control and status bundle for multi_clock_divider.
// The master drives the enables, sync and divisor writes. The slave returns the divided clocks, ticks and pending flags.
interface multi_clock_divider_if #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 28
);
   localparam int unsigned CHAN_W = 4;

   logic [CHANNELS-1:0] enable;
   logic                sync;
   logic                wr_en;
   logic [CHAN_W-1:0]   wr_chan;
   logic [WIDTH-1:0]    wr_div;
   logic [WIDTH-1:0]    wr_high;
   logic [CHANNELS-1:0] clock_out;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] pending;

   modport master (
      output enable, sync, wr_en, wr_chan, wr_div, wr_high,
      input  clock_out, tick, pending
   );

   modport slave (
      input  enable, sync, wr_en, wr_chan, wr_div, wr_high,
      output clock_out, tick, pending
   );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock/tick divider with shadowed divisors.
// Divisor updates apply at the period boundary, and a global sync restarts every channel at phase 0.
module multi_clock_divider #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned WIDTH        = 28,
   parameter int unsigned DEFAULT_DIV  = 2,
   parameter int unsigned DEFAULT_HIGH = 1
) (
   input  logic                  clock_in,
   input  logic                  rst_n,
   multi_clock_divider_if.slave  bus
);
   localparam int unsigned CHAN_W = 4;
   localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_HIGH);

   logic [WIDTH-1:0]    cnt_q    [CHANNELS];
   logic [WIDTH-1:0]    cnt_d    [CHANNELS];
   logic [WIDTH-1:0]    div_a_q  [CHANNELS];
   logic [WIDTH-1:0]    div_a_d  [CHANNELS];
   logic [WIDTH-1:0]    high_a_q [CHANNELS];
   logic [WIDTH-1:0]    high_a_d [CHANNELS];
   logic [WIDTH-1:0]    div_s_q  [CHANNELS];
   logic [WIDTH-1:0]    div_s_d  [CHANNELS];
   logic [WIDTH-1:0]    high_s_q [CHANNELS];
   logic [WIDTH-1:0]    high_s_d [CHANNELS];
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0] clk_out_q, clk_out_d;
   logic [CHANNELS-1:0] tick_q, tick_d;

   logic [CHANNELS-1:0] run_c, wrap_c, wr_hit_c, bound_c;

   // Per-channel next state: the boundary (halt, disable, sync or wrap) resets cnt and commits new divisors
   always_comb begin
      run_c     = '0;
      wrap_c    = '0;
      wr_hit_c  = '0;
      bound_c   = '0;
      pend_d    = pend_q;
      clk_out_d = '0;
      tick_d    = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         cnt_d[i]    = cnt_q[i];
         div_a_d[i]  = div_a_q[i];
         high_a_d[i] = high_a_q[i];
         div_s_d[i]  = div_s_q[i];
         high_s_d[i] = high_s_q[i];

         run_c[i]    = bus.enable[i] && (div_a_q[i] != '0);
         // div_a-1 only matters while running, so div_a=0 never reaches the compare
         wrap_c[i]   = run_c[i] && (cnt_q[i] >= (div_a_q[i] - WIDTH'(1)));
         wr_hit_c[i] = bus.wr_en && (bus.wr_chan == CHAN_W'(i));
         bound_c[i]  = !run_c[i] || bus.sync || wrap_c[i];

         clk_out_d[i] = run_c[i] && (cnt_q[i] < high_a_q[i]);
         tick_d[i]    = run_c[i] && (cnt_q[i] == '0);

         if (bound_c[i]) begin
            cnt_d[i] = '0;
            if (wr_hit_c[i]) begin
               div_a_d[i]  = bus.wr_div;
               high_a_d[i] = bus.wr_high;
               pend_d[i]   = 1'b0;
            end else if (pend_q[i]) begin
               div_a_d[i]  = div_s_q[i];
               high_a_d[i] = high_s_q[i];
               pend_d[i]   = 1'b0;
            end
         end else begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
            if (wr_hit_c[i]) begin
               div_s_d[i]  = bus.wr_div;
               high_s_d[i] = bus.wr_high;
               pend_d[i]   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_q[i]    <= '0;
            div_a_q[i]  <= RST_DIV;
            high_a_q[i] <= RST_HIGH;
            div_s_q[i]  <= RST_DIV;
            high_s_q[i] <= RST_HIGH;
         end
         pend_q    <= '0;
         clk_out_q <= '0;
         tick_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         div_a_q   <= div_a_d;
         high_a_q  <= high_a_d;
         div_s_q   <= div_s_d;
         high_s_q  <= high_s_d;
         pend_q    <= pend_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign bus.clock_out = clk_out_q;
   assign bus.tick      = tick_q;
   assign bus.pending   = pend_q;
endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider.
// A vector table covers the steady patterns and writes, followed by hand sequences for sync, halt/restart and async reset.
module tb_multi_clock_divider;
   localparam int unsigned CH = 4;
   localparam int unsigned W  = 28;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   multi_clock_divider_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

   multi_clock_divider #(
      .CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(2), .DEFAULT_HIGH(1)
   ) dut (
      .clock_in(clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         wr_en;
      logic [3:0]   chan;
      logic [W-1:0] div;
      logic [W-1:0] high;
      logic         sync;
      logic [3:0]   exp_clk;
      logic [3:0]   exp_tick;
      logic [3:0]   exp_pend;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(logic we, int ch, int dv, int hi, logic sy,
                               logic [3:0] ec, logic [3:0] et, logic [3:0] ep);
      vec_t v;
      v.wr_en = we; v.chan = 4'(ch); v.div = W'(dv); v.high = W'(hi); v.sync = sy;
      v.exp_clk = ec; v.exp_tick = et; v.exp_pend = ep;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input int ch, input int dv, input int hi, input logic sy);
      bus.wr_en   = we;
      bus.wr_chan = 4'(ch);
      bus.wr_div  = W'(dv);
      bus.wr_high = W'(hi);
      bus.sync    = sy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] ec, input logic [3:0] et);
      chk({tag, " clk"},  32'(bus.clock_out), 32'(ec));
      chk({tag, " tick"}, 32'(bus.tick),      32'(et));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.enable = 4'hF;
      drive(1'b0, 0, 0, 0, 1'b0);

      // Edge-by-edge table after reset release; row k is edge k
      vecs[0]  = mk(0, 0,  0, 0, 0, 4'hF, 4'hF, 4'h0);
      vecs[1]  = mk(0, 0,  0, 0, 0, 4'h0, 4'h0, 4'h0);
      vecs[2]  = mk(0, 0,  0, 0, 0, 4'hF, 4'hF, 4'h0);
      vecs[3]  = mk(1, 2,  4, 1, 0, 4'h0, 4'h0, 4'h0);  // write on a wrap edge loads directly
      vecs[4]  = mk(1, 1,  5, 2, 0, 4'hF, 4'hF, 4'h2);
      vecs[5]  = mk(1, 2, 10, 5, 0, 4'h0, 4'h0, 4'h4);
      vecs[6]  = mk(1, 2,  3, 2, 0, 4'hB, 4'hB, 4'h4);  // last write wins
      vecs[7]  = mk(0, 0,  0, 0, 0, 4'h2, 4'h0, 4'h0);
      vecs[8]  = mk(0, 0,  0, 0, 0, 4'hD, 4'hD, 4'h0);
      vecs[9]  = mk(1, 15, 0, 0, 0, 4'h4, 4'h0, 4'h0);  // out-of-range channel ignored
      vecs[10] = mk(0, 0,  0, 0, 0, 4'h9, 4'h9, 4'h0);
      vecs[11] = mk(0, 0,  0, 0, 0, 4'h6, 4'h6, 4'h0);
      vecs[12] = mk(0, 0,  0, 0, 0, 4'hF, 4'h9, 4'h0);
      vecs[13] = mk(1, 4,  0, 0, 0, 4'h0, 4'h0, 4'h0);
      vecs[14] = mk(0, 0,  0, 0, 0, 4'hD, 4'hD, 4'h0);
      vecs[15] = mk(0, 0,  0, 0, 0, 4'h4, 4'h0, 4'h0);
      vecs[16] = mk(0, 0,  0, 0, 0, 4'hB, 4'hB, 4'h0);

      #12;
      chk_all("reset", 4'h0, 4'h0);
      chk("reset pend", 32'(bus.pending), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 17; k++) begin
         drive(vecs[k].wr_en, int'(vecs[k].chan), int'(vecs[k].div), int'(vecs[k].high), vecs[k].sync);
         step();
         chk_all($sformatf("vec%0d", k + 1), vecs[k].exp_clk, vecs[k].exp_tick);
         chk($sformatf("vec%0d pend", k + 1), 32'(bus.pending), 32'(vecs[k].exp_pend));
      end

      // Sync: ch0 -> 3/1, ch1 -> 7/3 written together with sync (immediate load)
      drive(1'b1, 0, 3, 1, 1'b0);
      step();
      drive(1'b1, 1, 7, 3, 1'b1);
      step();
      chk("sync pend", 32'(bus.pending), 32'h0);
      drive(1'b0, 0, 0, 0, 1'b0);
      step(); chk_all("sync+1", 4'hF, 4'hF);
      step(); chk_all("sync+2", 4'h6, 4'h0);
      step(); chk_all("sync+3", 4'hA, 4'h8);
      step(); chk_all("sync+4", 4'h5, 4'h5);
      step(); chk_all("sync+5", 4'hC, 4'h8);
      step(); step();
      step(); chk_all("sync+8", 4'h6, 4'h2);

      // Halt ch3 through a shadowed write of div=0
      drive(1'b1, 3, 0, 0, 1'b0);
      step();
      drive(1'b0, 0, 0, 0, 1'b0);
      chk("halt pend", 32'(bus.pending[3]), 32'h1);
      chk("halt clk0", 32'(bus.clock_out[3]), 32'h1);
      step();
      chk("halt pend clr", 32'(bus.pending[3]), 32'h0);
      chk("halt clk1", 32'(bus.clock_out[3]), 32'h0);
      for (int k = 0; k < 2; k++) begin
         step();
         chk($sformatf("halted clk%0d", k), 32'(bus.clock_out[3]), 32'h0);
         chk($sformatf("halted tick%0d", k), 32'(bus.tick[3]), 32'h0);
      end

      // Restart halted ch3 with high >= div: constant high, tick every 4
      drive(1'b1, 3, 4, 4, 1'b0);
      step();
      drive(1'b0, 0, 0, 0, 1'b0);
      chk("restart pend", 32'(bus.pending[3]), 32'h0);
      chk("restart clk", 32'(bus.clock_out[3]), 32'h0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("hi clk%0d", k), 32'(bus.clock_out[3]), 32'h1);
         chk($sformatf("hi tick%0d", k), 32'(bus.tick[3]), (k % 4 == 0) ? 32'h1 : 32'h0);
      end

      // Asynchronous reset mid-period
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async rst", 4'h0, 4'h0);
      chk("async rst pend", 32'(bus.pending), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(); chk_all("post rst1", 4'hF, 4'hF);
      step(); chk_all("post rst2", 4'h0, 4'h0);
      step(); chk_all("post rst3", 4'hF, 4'hF);
      chk("post rst pend", 32'(bus.pending), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
